// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, shifter modes, flag indices and FSM states shared by the ALU.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_SRA   = 4'b0100;
  localparam logic [3:0] OP_ROL   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_AND   = 4'b1100;
  localparam logic [3:0] OP_PASSA = 4'b1110;
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;
  localparam logic [1:0] SH_ROL = 2'd3;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_C = 0;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
endpackage

// File: rtl/alu_seq_shift.sv
// barrel_shift_p: combinational SLL/SRL/SRA/ROL with the last bit shifted out as carry.
module barrel_shift_p
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o
);
  logic [WIDTH-1:0] sll_r, srl_r, sra_r, rol_r;
  logic sll_c, srl_c, sra_c;
  // One guard bit beyond the result catches the last bit out; it reads 0 when amt is 0.
  assign {sll_c, sll_r} = {1'b0, a_i} << amt_i;
  assign {srl_r, srl_c} = {a_i, 1'b0} >> amt_i;
  assign {sra_r, sra_c} = $signed({a_i, 1'b0}) >>> amt_i;
  assign rol_r = (a_i << amt_i) | (a_i >> (WIDTH - int'(amt_i)));
  always_comb begin
    res_o = mode_i == SH_SLL ? sll_r : mode_i == SH_SRL ? srl_r : mode_i == SH_SRA ? sra_r : rol_r;
    c_o   = mode_i == SH_SLL ? sll_c : mode_i == SH_SRL ? srl_c : mode_i == SH_SRA ? sra_c : (|amt_i & rol_r[0]);
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with Z/N/C flags, shift-add MUL and valid/ready on both sides.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] src_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] res_out,
  output logic [2:0]       flags_out
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sh_r, alu_r;
  logic [2:0] flags_q, flags_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] psum_q, psum_d, psum_nx;
  logic [WIDTH:0] add_s, sub_s;
  logic sh_c, alu_c, accept;

  function automatic logic [2:0] mk_flags(input logic [WIDTH-1:0] r, input logic c);
    mk_flags = '0;
    mk_flags[F_Z] = ~|r;
    mk_flags[F_N] = r[WIDTH-1];
    mk_flags[F_C] = c;
  endfunction

  assign ready_out = state_q == S_IDLE || (state_q == S_DONE && ready_in);
  assign accept    = valid_in & ready_out;
  assign valid_out = state_q == S_DONE;
  assign res_out   = res_q;
  assign flags_out = flags_q;
  assign add_s = {1'b0, acc_in} + {1'b0, src_in};
  assign sub_s = {1'b0, acc_in} + {1'b0, ~src_in} + {{WIDTH{1'b0}}, 1'b1};
  assign psum_nx = psum_q + (b_q[cnt_q] ? {{WIDTH{1'b0}}, a_q} << cnt_q : '0);

  barrel_shift_p #(.WIDTH(WIDTH)) u_shift (
    .a_i   (acc_in),
    .amt_i (src_in[SHW-1:0]),
    .mode_i(op_in[1:0] - 2'd2),
    .res_o (sh_r),
    .c_o   (sh_c)
  );

  always_comb begin
    case (op_in)
      OP_ADD:                         {alu_c, alu_r} = add_s;
      OP_SUB:                         {alu_c, alu_r} = sub_s;
      OP_SLL, OP_SRL, OP_SRA, OP_ROL: {alu_c, alu_r} = {sh_c, sh_r};
      OP_PASSB:                       {alu_c, alu_r} = {1'b0, src_in};
      OP_OR:                          {alu_c, alu_r} = {1'b0, acc_in | src_in};
      OP_XOR:                         {alu_c, alu_r} = {1'b0, acc_in ^ src_in};
      OP_AND:                         {alu_c, alu_r} = {1'b0, acc_in & src_in};
      OP_PASSA:                       {alu_c, alu_r} = {1'b0, acc_in};
      default:                        {alu_c, alu_r} = {1'b0, acc_in};
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (state_q == S_MUL) begin
      psum_d = psum_nx;
      cnt_d  = cnt_q + 1'b1;
      // The counter wraps to 0 on the last step because WIDTH is a power of two.
      if (cnt_q == SHW'(WIDTH - 1)) begin
        state_d = S_DONE;
        res_d   = psum_nx[WIDTH-1:0];
        flags_d = mk_flags(psum_nx[WIDTH-1:0], |psum_nx[2*WIDTH-1:WIDTH]);
      end
    end else begin
      if (state_q == S_DONE && ready_in) state_d = S_IDLE;
      if (accept && op_in == OP_MUL) begin
        state_d = S_MUL;
        a_d     = acc_in;
        b_d     = src_in;
        cnt_d   = '0;
        psum_d  = '0;
      end else if (accept) begin
        state_d = S_DONE;
        res_d   = alu_r;
        flags_d = mk_flags(alu_r, alu_c);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      psum_q  <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random stimulus against an arithmetic reference model of alu_seq.
module tb_alu_seq;
  localparam int W = 8;
  logic clk_in = 1'b0;
  logic rst_in, valid_in, ready_in, ready_out, valid_out;
  logic [3:0] op_in;
  logic [7:0] acc_in, src_in, res_out;
  logic [2:0] flags_out;
  int checks = 0;
  int failures = 0;
  logic m_valid;
  int m_busy;
  logic [7:0] m_res, p_res;
  logic [2:0] m_flags, p_flags;

  alu_seq #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .op_in(op_in), .acc_in(acc_in), .src_in(src_in), .valid_out(valid_out),
    .ready_in(ready_in), .res_out(res_out), .flags_out(flags_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void ref_op(input logic [3:0] op, input int a, input int b,
                                 output logic [7:0] r, output logic [2:0] f);
    int amt, x;
    logic c;
    amt = b % 8;
    c = 1'b0;
    case (op)
      4'h0: begin x = a + b; c = x > 255; end
      4'h1: begin x = a - b; c = a >= b; end
      4'h2: begin x = a << amt; c = amt != 0 && ((a >> (8 - amt)) & 1) != 0; end
      4'h3: begin x = a >> amt; c = amt != 0 && ((a >> (amt - 1)) & 1) != 0; end
      4'h4: begin x = (a >= 128 ? a - 256 : a) >>> amt; c = amt != 0 && ((a >> (amt - 1)) & 1) != 0; end
      4'h5: begin x = (a << amt) | (a >> (8 - amt)); c = amt != 0 && (x & 1) != 0; end
      4'h6: begin x = a * b; c = x > 255; end
      4'h7: x = b;
      4'h8: x = a | b;
      4'hA: x = a ^ b;
      4'hC: x = a & b;
      default: x = a;
    endcase
    r = 8'(x & 255);
    f = {r == 8'h00, r[7], c};
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic mod_reset();
    m_valid = 1'b0;
    m_busy  = 0;
    m_res   = 8'h00;
    m_flags = 3'b000;
  endtask

  // Drive one cycle just after a falling edge, predict the next state, then compare on the next falling edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic rdy);
    logic m_rdy;
    logic [7:0] r;
    logic [2:0] f;
    valid_in = v; op_in = op; acc_in = a; src_in = b; ready_in = rdy;
    #1;
    m_rdy = m_busy == 0 && (!m_valid || rdy);
    chk("ready_out", ready_out, m_rdy);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_valid = 1'b1; m_res = p_res; m_flags = p_flags; end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (v && m_rdy) begin
        ref_op(op, int'(a), int'(b), r, f);
        if (op == 4'h6) begin m_busy = W; p_res = r; p_flags = f; end
        else begin m_valid = 1'b1; m_res = r; m_flags = f; end
      end
    end
    @(negedge clk_in);
    chk("valid_out", valid_out, m_valid);
    if (m_valid) begin
      chk("res_out", res_out, m_res);
      chk("flags_out", flags_out, m_flags);
    end
  endtask

  task automatic dir(input string n, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] er, input logic [2:0] ef);
    step(1'b1, op, a, b, 1'b1);
    chk({n, "_valid"}, valid_out, 1'b1);
    chk({n, "_res"}, res_out, er);
    chk({n, "_flags"}, flags_out, ef);
  endtask

  task automatic mul_dir(input string n, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [2:0] ef);
    step(1'b1, 4'h6, a, b, 1'b1);
    for (int i = 0; i < W - 1; i++) begin
      step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
      chk({n, "_busy_valid"}, valid_out, 1'b0);
    end
    step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
    chk({n, "_valid"}, valid_out, 1'b1);
    chk({n, "_res"}, res_out, er);
    chk({n, "_flags"}, flags_out, ef);
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1; op_in = 4'h0; acc_in = 8'h00; src_in = 8'h00;
    mod_reset();
    repeat (2) @(negedge clk_in);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_res", res_out, 8'h00);
    chk("rst_flags", flags_out, 3'b000);
    rst_in = 1'b0;
    dir("add_ff_01", 4'h0, 8'hFF, 8'h01, 8'h00, 3'b101);
    dir("sub_5_7", 4'h1, 8'h05, 8'h07, 8'hFE, 3'b010);
    dir("sub_7_7", 4'h1, 8'h07, 8'h07, 8'h00, 3'b101);
    dir("sra_80_3", 4'h4, 8'h80, 8'h03, 8'hF0, 3'b010);
    dir("srl_81_1", 4'h3, 8'h81, 8'h01, 8'h40, 3'b001);
    dir("rol_81_1", 4'h5, 8'h81, 8'h01, 8'h03, 3'b001);
    dir("sll_81_0", 4'h2, 8'h81, 8'h08, 8'h81, 3'b010);
    mul_dir("mul_13_11", 8'd13, 8'd11, 8'h8F, 3'b010);
    mul_dir("mul_16_16", 8'd16, 8'd16, 8'h00, 3'b101);
    dir("add_5_5", 4'h0, 8'h05, 8'h05, 8'h0A, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h1, 8'($urandom), 8'($urandom), 1'b0);
      chk("bp_ready", ready_out, 1'b0);
      chk("bp_res", res_out, 8'h0A);
    end
    dir("bp_add_1_2", 4'h0, 8'h01, 8'h02, 8'h03, 3'b000);
    step(1'b1, 4'h6, 8'd13, 8'd11, 1'b1);
    repeat (3) step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
    rst_in = 1'b1;
    #1;
    chk("abort_valid", valid_out, 1'b0);
    chk("abort_res", res_out, 8'h00);
    chk("abort_flags", flags_out, 3'b000);
    chk("abort_ready", ready_out, 1'b1);
    mod_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    dir("post_add_2_2", 4'h0, 8'h02, 8'h02, 8'h04, 3'b000);
    repeat (2) step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
    chk("post_mul_residue", valid_out, 1'b0);
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
